datapath_arbiter: RTL and testbench

//  Shares one iterative shift/add datapath and its controller among NREQ requesters.

---
 rtl/arb_pkg.sv | 17 +
 rtl/datapath_arbiter_if.sv | 34 +++
 rtl/datapath_arbiter_rr_pick.sv | 32 +++
 rtl/datapath_arbiter.sv | 141 ++++++++++++++
 tb/tb_datapath_arbiter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the datapath arbiter slice.
// Contents: FSM state encoding and default sizing constants used by
// the interface, the round-robin picker and the arbiter top.
package arb_pkg;

  localparam int unsigned DEF_NREQ    = 4;
  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/datapath_arbiter_if.sv
// Bundle of requester-side and datapath-side signals of the arbiter.
// master: arbiter view (drives done/result/err/busy and dp_start/dp_a/dp_b)
// slave : environment view (drives req/req_a/req_b and dp_valid/dp_result)
interface datapath_arbiter_if
  import arb_pkg::*;
#(
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      result;
  logic                  err;
  logic                  busy;
  logic                  dp_start;
  logic [WIDTH-1:0]      dp_a;
  logic [WIDTH-1:0]      dp_b;
  logic                  dp_valid;
  logic [WIDTH-1:0]      dp_result;

  modport master (
    input  req, req_a, req_b, dp_valid, dp_result,
    output done, result, err, busy, dp_start, dp_a, dp_b
  );

  modport slave (
    output req, req_a, req_b, dp_valid, dp_result,
    input  done, result, err, busy, dp_start, dp_a, dp_b
  );

endinterface

// File: rtl/datapath_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports: req  - request vector
//        last - index of the most recent grant
//        any  - at least one request is pending
//        idx  - first requester with req set, searching last+1, last+2, ...
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic            any,
  output logic [LW-1:0]   idx
);

  int unsigned cand;

  // Walk the ring starting just after the last winner; first hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last) + k) % NREQ;
      if (!any && req[LW'(cand)]) begin
        any = 1'b1;
        idx = LW'(cand);
      end
    end
  end

endmodule

// File: rtl/datapath_arbiter.sv
// Shares one iterative datapath among NREQ requesters.
// Round-robin grant, operand latch, dp_start pulse, wait for dp_valid or
// watchdog timeout, then a one-cycle done pulse to the winner.
// Ports: clk, reset (sync, active-low), bus (datapath_arbiter_if.master).
module datapath_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  datapath_arbiter_if.master  bus
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT);

  arb_state_e        state, state_d;
  logic [LW-1:0]     gidx, gidx_d;
  logic [LW-1:0]     last, last_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic [WIDTH-1:0]  dpa_q, dpa_d;
  logic [WIDTH-1:0]  dpb_q, dpb_d;

  logic              pick_any;
  logic [LW-1:0]     pick_idx;
  logic [WIDTH-1:0]  opa [NREQ];
  logic [WIDTH-1:0]  opb [NREQ];

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign opa[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign opb[i] = bus.req_b[i*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
    .req  (bus.req),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      gidx     <= '0;
      last     <= LW'(NREQ - 1);
      cnt      <= '0;
      done_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      start_q  <= 1'b0;
      dpa_q    <= '0;
      dpb_q    <= '0;
    end else begin
      state    <= state_d;
      gidx     <= gidx_d;
      last     <= last_d;
      cnt      <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      start_q  <= start_d;
      dpa_q    <= dpa_d;
      dpb_q    <= dpb_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so that the
  // registered value lines up with the state it belongs to.
  always_comb begin
    state_d  = state;
    gidx_d   = gidx;
    last_d   = last;
    cnt_d    = cnt;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    start_d  = 1'b0;
    dpa_d    = dpa_q;
    dpb_d    = dpb_q;

    unique case (state)
      IDLE: begin
        if (pick_any) begin
          gidx_d  = pick_idx;
          dpa_d   = opa[pick_idx];
          dpb_d   = opb[pick_idx];
          start_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // dp_valid wins over a timeout landing on the same cycle.
        if (bus.dp_valid) begin
          result_d     = bus.dp_result;
          err_d        = 1'b0;
          done_d[gidx] = 1'b1;
          state_d      = RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          result_d     = '0;
          err_d        = 1'b1;
          done_d[gidx] = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      RESP: begin
        last_d  = gidx;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.dp_start = start_q;
  assign bus.dp_a     = dpa_q;
  assign bus.dp_b     = dpb_q;

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter: reset, round-robin order, single
// request, watchdog, dp_valid/timeout collision and reset mid-operation.
module tb_datapath_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  datapath_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

  datapath_arbiter #(.NREQ(4), .WIDTH(8), .TIMEOUT(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for dp_start at a falling edge.
  task automatic wait_start(input string tag);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.dp_start) break;
    end
    chk({tag, "_start"}, 32'(bus.dp_start), 32'h1);
  endtask

  // One operation: respond k cycles after the dp_start cycle. With early set,
  // a bogus dp_valid is also presented during ISSUE and must be ignored.
  task automatic do_op(input int k, input logic [7:0] res, input logic [3:0] exp_g,
                       input logic [7:0] ea, input logic [7:0] eb, input bit early,
                       input string tag);
    int rem;
    wait_start(tag);
    chk({tag, "_a"}, 32'(bus.dp_a), 32'(ea));
    chk({tag, "_b"}, 32'(bus.dp_b), 32'(eb));
    chk({tag, "_busy"}, 32'(bus.busy), 32'h1);
    rem = k;
    if (early) begin
      bus.dp_valid  = 1'b1;
      bus.dp_result = 8'hEE;
      @(negedge clk);
      bus.dp_valid  = 1'b0;
      rem = k - 1;
    end
    repeat (rem) @(negedge clk);
    bus.dp_valid  = 1'b1;
    bus.dp_result = res;
    @(negedge clk);
    bus.dp_valid  = 1'b0;
    chk({tag, "_done"}, 32'(bus.done), 32'(exp_g));
    chk({tag, "_res"}, 32'(bus.result), 32'(res));
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    bus.req = bus.req & ~exp_g;
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'h0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    reset         = 1'b0;
    bus.req       = 4'b1111;
    bus.req_a     = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.req_b     = {8'h23, 8'h22, 8'h21, 8'h20};
    bus.dp_valid  = 1'b0;
    bus.dp_result = 8'h00;

    // Reset held with all requests pending.
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_start", 32'(bus.dp_start), 32'h0);
    chk("rst_dpa", 32'(bus.dp_a), 32'h0);
    chk("rst_dpb", 32'(bus.dp_b), 32'h0);
    reset = 1'b1;

    // Round-robin 0,1,2,3 then 0,2.
    do_op(3, 8'hA0, 4'b0001, 8'h10, 8'h20, 1'b0, "rr0");
    do_op(4, 8'hA1, 4'b0010, 8'h11, 8'h21, 1'b0, "rr1");
    do_op(2, 8'hA2, 4'b0100, 8'h12, 8'h22, 1'b0, "rr2");
    do_op(5, 8'hA3, 4'b1000, 8'h13, 8'h23, 1'b0, "rr3");
    bus.req = 4'b0101;
    do_op(3, 8'hB0, 4'b0001, 8'h10, 8'h20, 1'b0, "rr4");
    do_op(3, 8'hB2, 4'b0100, 8'h12, 8'h22, 1'b0, "rr5");

    // Single request with the 17-cycle controller latency.
    bus.req_a[23:16] = 8'h2D;
    bus.req_b[23:16] = 8'h05;
    bus.req = 4'b0100;
    do_op(17, 8'h09, 4'b0100, 8'h2D, 8'h05, 1'b0, "single");

    // Watchdog: no dp_valid; done 32 cycles after WAIT entry (33 after dp_start).
    bus.req = 4'b0001;
    wait_start("wd");
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.done != 4'b0000) break;
    end
    chk("wd_latency", 32'(cyc), 32'd33);
    chk("wd_done", 32'(bus.done), 32'h1);
    chk("wd_err", 32'(bus.err), 32'h1);
    chk("wd_res", 32'(bus.result), 32'h0);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("wd_pulse", 32'(bus.done), 32'h0);

    // dp_valid on the last timeout cycle wins.
    bus.req = 4'b0001;
    do_op(32, 8'h5A, 4'b0001, 8'h10, 8'h20, 1'b0, "simul");

    // Reset mid-WAIT aborts silently and restores the grant pointer.
    bus.req = 4'b0010;
    wait_start("abort");
    chk("abort_a", 32'(bus.dp_a), 32'h11);
    repeat (5) @(negedge clk);
    reset   = 1'b0;
    bus.req = 4'b0011;
    @(negedge clk);
    chk("abort_done", 32'(bus.done), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_start", 32'(bus.dp_start), 32'h0);
    reset = 1'b1;
    do_op(4, 8'h33, 4'b0001, 8'h10, 8'h20, 1'b1, "post_rst");
    do_op(4, 8'h77, 4'b0010, 8'h11, 8'h21, 1'b0, "post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
